// File: rtl/aes_ctrl_pkg.sv
// Shared types and GF(2^8) helpers for the AES round sequencer.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
    endfunction

    // Round constant reached after n encrypt steps from 0x01.
    function automatic logic [7:0] rcon_after(input int unsigned n);
        logic [7:0] r;
        r = 8'h01;
        for (int unsigned i = 0; i < n; i++) begin
            r = xtime(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/rcon_step.sv
// Combinational one-round Rcon advance, forward (encrypt) or inverse (decrypt).
module rcon_step
    import aes_ctrl_pkg::*;
(
    input  logic [7:0] rcon_i,
    input  logic       decrypt_i,
    output logic [7:0] rcon_o
);

    assign rcon_o = decrypt_i ? inv_xtime(rcon_i) : xtime(rcon_i);

endmodule

// File: rtl/aes_round_sequencer.sv
// Round/cycle sequencer driving key-register, guard and Rcon controls of the
// masked round-based AES datapath.
module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned SBOX_LATENCY     = 10,
    parameter int unsigned NUM_ROUNDS       = 10,
    parameter int unsigned GUARD_LOAD_CYCLE = 4,
    parameter int unsigned GUARD_MUX_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       decrypt,
    output logic       busy,
    output logic       done,
    output logic       FinalRound,
    output logic       KeyRegEn,
    output logic       Guards_MUX_sel,
    output logic       Guards_KeyReg_EN,
    output logic [7:0] Rcon,
    output logic [3:0] RoundIdx
);

    if (SBOX_LATENCY < 2 || SBOX_LATENCY > 32) begin : g_bad_latency
        $error("SBOX_LATENCY must be in 2..32");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 14) begin : g_bad_rounds
        $error("NUM_ROUNDS must be in 1..14");
    end
    if (GUARD_LOAD_CYCLE >= SBOX_LATENCY) begin : g_bad_guard_load
        $error("GUARD_LOAD_CYCLE must be below SBOX_LATENCY");
    end
    if (GUARD_MUX_CYCLES > SBOX_LATENCY) begin : g_bad_guard_mux
        $error("GUARD_MUX_CYCLES must not exceed SBOX_LATENCY");
    end

    localparam logic [7:0] RconLast  = rcon_after(NUM_ROUNDS - 1);
    localparam logic [4:0] CntLast   = 5'(SBOX_LATENCY - 1);
    localparam logic [4:0] GuardLoad = 5'(GUARD_LOAD_CYCLE);
    localparam logic [5:0] GuardMux  = 6'(GUARD_MUX_CYCLES);
    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS - 1);

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;
    logic       dec_q, dec_d;
    logic [7:0] rcon_next;

    rcon_step u_rcon_step (
        .rcon_i    (rcon_q),
        .decrypt_i (dec_q),
        .rcon_o    (rcon_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            dec_q   <= dec_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        round_d          = round_q;
        rcon_d           = rcon_q;
        dec_d            = dec_q;
        busy             = 1'b0;
        done             = 1'b0;
        FinalRound       = 1'b0;
        KeyRegEn         = 1'b0;
        Guards_MUX_sel   = 1'b0;
        Guards_KeyReg_EN = 1'b0;
        Rcon             = rcon_q;
        RoundIdx         = round_q;

        case (state_q)
            StIdle: begin
                // Initial Rcon is visible before start so the key schedule can pre-load it.
                Rcon             = decrypt ? RconLast : 8'h01;
                Guards_MUX_sel   = 1'b1;
                KeyRegEn         = start;
                Guards_KeyReg_EN = start;
                if (start) begin
                    state_d = StRun;
                    cnt_d   = 5'd0;
                    round_d = 4'd0;
                    rcon_d  = Rcon;
                    dec_d   = decrypt;
                end
            end
            StRun: begin
                busy             = 1'b1;
                FinalRound       = (round_q == LastRound);
                KeyRegEn         = (cnt_q == CntLast);
                Guards_KeyReg_EN = (cnt_q == GuardLoad);
                Guards_MUX_sel   = (round_q == 4'd0) && ({1'b0, cnt_q} < GuardMux);
                if (cnt_q == CntLast) begin
                    cnt_d  = 5'd0;
                    rcon_d = rcon_next;
                    if (round_q == LastRound) begin
                        state_d = StDone;
                        round_d = 4'd0;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: two sequencer instances (default and short config)
// compared every cycle against an offset-based behavioural model.
module tb_aes_round_sequencer;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       fr;
        logic       kre;
        logic       gke;
        logic       mux;
        logic [7:0] rcon;
        logic [3:0] ridx;
        logic       chk_rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, dec_a = 1'b0, start_b = 1'b0, dec_b = 1'b0;
    logic busy_a, done_a, fr_a, kre_a, mux_a, gke_a;
    logic busy_b, done_b, fr_b, kre_b, mux_b, gke_b;
    logic [7:0] rcon_a, rcon_b;
    logic [3:0] ridx_a, ridx_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_round_sequencer u_dut_a (
        .clk              (clk),
        .rst              (rst),
        .start            (start_a),
        .decrypt          (dec_a),
        .busy             (busy_a),
        .done             (done_a),
        .FinalRound       (fr_a),
        .KeyRegEn         (kre_a),
        .Guards_MUX_sel   (mux_a),
        .Guards_KeyReg_EN (gke_a),
        .Rcon             (rcon_a),
        .RoundIdx         (ridx_a)
    );

    aes_round_sequencer #(
        .SBOX_LATENCY     (4),
        .NUM_ROUNDS       (2),
        .GUARD_LOAD_CYCLE (2),
        .GUARD_MUX_CYCLES (3)
    ) u_dut_b (
        .clk              (clk),
        .rst              (rst),
        .start            (start_b),
        .decrypt          (dec_b),
        .busy             (busy_b),
        .done             (done_b),
        .FinalRound       (fr_b),
        .KeyRegEn         (kre_b),
        .Guards_MUX_sel   (mux_b),
        .Guards_KeyReg_EN (gke_b),
        .Rcon             (rcon_b),
        .RoundIdx         (ridx_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Round constant of round r: powers of x in GF(2^8), reversed for decrypt.
    function automatic logic [7:0] rcon_model(input int nr, input int r, input logic dec);
        int idx, v;
        idx = dec ? (nr - 1 - r) : r;
        v = 1;
        for (int i = 0; i < idx; i++) begin
            v = v * 2;
            if (v > 255) v = v ^ 'h11b;
        end
        return 8'(v);
    endfunction

    // off = 0 idle, 1..NR*L run cycles, NR*L+1 the done cycle.
    function automatic exp_t model(input int l, input int nr, input int g, input int gm,
                                   input int off, input logic mode, input logic st,
                                   input logic dec);
        exp_t e;
        int r, c;
        e = '0;
        e.chk_rd = 1'b1;
        if (off == 0) begin
            e.mux  = 1'b1;
            e.kre  = st;
            e.gke  = st;
            e.rcon = rcon_model(nr, 0, dec);
        end else if (off <= nr * l) begin
            r = (off - 1) / l;
            c = (off - 1) % l;
            e.busy = 1'b1;
            e.fr   = (r == nr - 1);
            e.kre  = (c == l - 1);
            e.gke  = (c == g);
            e.mux  = (r == 0) && (c < gm);
            e.rcon = rcon_model(nr, r, mode);
            e.ridx = 4'(r);
        end else begin
            e.busy   = 1'b1;
            e.done   = 1'b1;
            e.chk_rd = 1'b0;
        end
        return e;
    endfunction

    task automatic cmp(input string p, input exp_t e, input logic b, input logic d,
                       input logic f, input logic k, input logic gk, input logic m,
                       input logic [7:0] rc, input logic [3:0] ri);
        chk({p, ".busy"}, 32'(b), 32'(e.busy));
        chk({p, ".done"}, 32'(d), 32'(e.done));
        chk({p, ".FinalRound"}, 32'(f), 32'(e.fr));
        chk({p, ".KeyRegEn"}, 32'(k), 32'(e.kre));
        chk({p, ".Guards_KeyReg_EN"}, 32'(gk), 32'(e.gke));
        chk({p, ".Guards_MUX_sel"}, 32'(m), 32'(e.mux));
        if (e.chk_rd) begin
            chk({p, ".Rcon"}, 32'(rc), 32'(e.rcon));
            chk({p, ".RoundIdx"}, 32'(ri), 32'(e.ridx));
        end
    endtask

    task automatic advance(inout int off, inout logic mode, input logic st, input logic dec,
                           input int total);
        if (off == 0) begin
            if (st) begin
                off  = 1;
                mode = dec;
            end
        end else if (off == total + 1) begin
            off = 0;
        end else begin
            off++;
        end
    endtask

    int   off_a = 0, off_b = 0;
    logic mode_a = 1'b0, mode_b = 1'b0;
    logic valid = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid) begin
                e = model(10, 10, 4, 5, off_a, mode_a, start_a, dec_a);
                cmp("A", e, busy_a, done_a, fr_a, kre_a, gke_a, mux_a, rcon_a, ridx_a);
                e = model(4, 2, 2, 3, off_b, mode_b, start_b, dec_b);
                cmp("B", e, busy_b, done_b, fr_b, kre_b, gke_b, mux_b, rcon_b, ridx_b);
            end
            if (rst) begin
                valid = 1'b1;
                off_a = 0;
                off_b = 0;
            end else if (valid) begin
                advance(off_a, mode_a, start_a, dec_a, 100);
                advance(off_b, mode_b, start_b, dec_b, 8);
            end
        end
    end

    // Entered at posedge+1 of the start cycle t; returns in the done cycle with lat = offset.
    task automatic launch(input logic sel, input logic noise, output int lat);
        lat = 0;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (noise && lat == 30) start_a = 1'b1;
            if (noise && lat == 31) start_a = 1'b0;
        end while (!(sel ? done_b : done_a) && lat < 300);
    endtask

    logic [7:0] enc_ref [10];
    int lat, ndone;

    initial begin
        enc_ref = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int r = 0; r < 10; r++) begin
            chk("model_rcon_enc", 32'(rcon_model(10, r, 1'b0)), 32'(enc_ref[r]));
            chk("model_rcon_dec", 32'(rcon_model(10, r, 1'b1)), 32'(enc_ref[9 - r]));
        end
        chk("model_rcon_short_dec", 32'(rcon_model(2, 0, 1'b1)), 32'h02);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_mux_sel", 32'(mux_a), 32'h1);
        chk("reset_busy", 32'(busy_a), 32'h0);
        chk("reset_rcon", 32'(rcon_a), 32'h01);

        launch(1'b0, 1'b0, lat);
        chk("enc_done_latency", 32'(lat), 32'd101);
        repeat (2) @(posedge clk);
        #1;

        dec_a = 1'b1;
        #1;
        chk("idle_rcon_dec", 32'(rcon_a), 32'h36);
        launch(1'b0, 1'b0, lat);
        chk("dec_done_latency", 32'(lat), 32'd101);
        dec_a = 1'b0;
        @(posedge clk);
        #1;

        // start mid-run and during done is ignored; start right after done is taken
        launch(1'b0, 1'b1, lat);
        chk("noise_done_latency", 32'(lat), 32'd101);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_done", 32'(busy_a), 32'h0);
        launch(1'b0, 1'b0, lat);
        chk("b2b_done_latency", 32'(lat), 32'd101);
        @(posedge clk);
        #1;

        // reset at t+37
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (36) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy_a), 32'h0);
        chk("rst_mid_mux", 32'(mux_a), 32'h1);
        ndone = 0;
        repeat (110) begin
            @(posedge clk);
            #1;
            if (done_a) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'd0);
        launch(1'b0, 1'b0, lat);
        chk("post_rst_latency", 32'(lat), 32'd101);
        @(posedge clk);
        #1;

        // rst beats start
        rst = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_a = 1'b0;
        chk("rst_over_start", 32'(busy_a), 32'h0);
        @(posedge clk);
        #1;

        dec_b = 1'b1;
        #1;
        chk("b_idle_rcon_dec", 32'(rcon_b), 32'h02);
        launch(1'b1, 1'b0, lat);
        chk("b_dec_latency", 32'(lat), 32'd9);
        dec_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        launch(1'b1, 1'b0, lat);
        chk("b_enc_latency", 32'(lat), 32'd9);
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Round/cycle sequencer for the masked round-based AES datapath. It generalises the fixed-latency encryption-only controller to four things: a configurable S-box pipeline latency, a configurable round count, encryption and decryption Rcon sequencing, and a start/busy/done handshake. It drives the round-key register enable, the guard-share multiplexer and register enables, the final-round flag and the round constant. It sits beside the datapath and key schedule and is the only source of their control strobes.

## Interface
Parameters:
- SBOX_LATENCY, 10, cycles per round (pipeline depth of the masked S-box); legal range 2..32
- NUM_ROUNDS, 10, rounds per operation; legal range 1..14
- GUARD_LOAD_CYCLE, 4, in-round cycle index at which the guard register loads; must be < SBOX_LATENCY
- GUARD_MUX_CYCLES, 5, number of leading cycles of round 0 during which the guard mux selects fresh guards; must be ≤ SBOX_LATENCY

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request an operation; sampled only in IDLE
- decrypt  in  1  mode, sampled with an accepted start; 1 selects inverse Rcon order
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after the last round
- FinalRound  out  1  high during every cycle of round NUM_ROUNDS-1
- KeyRegEn  out  1  round-key register load strobe
- Guards_MUX_sel  out  1  1 = guard mux selects fresh/initial guards
- Guards_KeyReg_EN  out  1  guard register load strobe
- Rcon  out  8  round constant for the current round
- RoundIdx  out  4  current round number, 0..NUM_ROUNDS-1

## Operation
State machine:
- States: IDLE, RUN, DONE.
- IDLE → RUN on start. RUN → DONE when the cycle counter is SBOX_LATENCY-1 and RoundIdx is NUM_ROUNDS-1. DONE → IDLE unconditionally.
- start in RUN or DONE is ignored. The mode latched at start is held for the whole run.

Counters:
- Cycle counter, 5 bits: counts 0..SBOX_LATENCY-1 in RUN and wraps to 0.
- RoundIdx increments on wrap.
- Rcon register advances on wrap: encrypt uses xtime, so b ← {b[6:0],0} ^ (b[7] ? 0x1B : 0).
- Decrypt uses inverse xtime: b ← b[0] ? ((b ^ 0x1B) >> 1) | 0x80 : b >> 1.

Initial Rcon:
- Encrypt starts at 0x01.
- Decrypt starts at RCON_LAST = xtime^(NUM_ROUNDS-1)(0x01), computed at elaboration. For the default this is 0x36.
- In IDLE, Rcon shows the initial value for the current decrypt input, so the key schedule can pre-load it.

Strobes:
- KeyRegEn: high in IDLE when start=1 (initial key load); in RUN, high when counter = SBOX_LATENCY-1.
- Guards_KeyReg_EN: high in IDLE when start=1; in RUN, high when counter = GUARD_LOAD_CYCLE.
- Guards_MUX_sel: high in IDLE; in RUN, high when RoundIdx = 0 and counter < GUARD_MUX_CYCLES; otherwise low.
- FinalRound: high in RUN when RoundIdx = NUM_ROUNDS-1.
- done: high in DONE only.

Reset values: state IDLE, counter 0, RoundIdx 0, Rcon register 0x01. Outputs in reset: busy 0, done 0, FinalRound 0, KeyRegEn 0, Guards_KeyReg_EN 0, Guards_MUX_sel 1. Rcon is 0x01, or RCON_LAST when decrypt=1.

Boundary conditions:
- rst asserted mid-RUN or in DONE returns to IDLE on the next edge. No done pulse is produced.
- rst has priority over start.
- NUM_ROUNDS = 1: FinalRound is high for the whole run, and Guards_MUX_sel and FinalRound overlap.

## Timing
- start accepted at edge t: RUN spans cycles t+1 .. t+NUM_ROUNDS·SBOX_LATENCY; done is high in cycle t+NUM_ROUNDS·SBOX_LATENCY+1. The default is done at t+101.
- The next start can be accepted at the earliest in the cycle after done, so back-to-back operations have a period of NUM_ROUNDS·SBOX_LATENCY+2.
- All outputs except the IDLE-cycle strobes and the IDLE Rcon are decoded from registered state. The IDLE-cycle strobes and the IDLE Rcon are combinational from start and decrypt.

## Structure
- Package aes_ctrl_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - functions xtime, inv_xtime and rcon_after(n).
- The parameter-legality checks live in the module as elaboration-time assertions.
- One sub-module, rcon_step, is combinational: it takes an 8-bit Rcon and a decrypt bit and returns the next Rcon.

## Test plan
- Default parameters, encrypt: rst, then start at t → Rcon per round is 01,02,04,08,10,20,40,80,1B,36; KeyRegEn at t and t+10k; FinalRound high t+91..t+100; done at t+101 only.
- Default parameters, decrypt → Rcon per round is 36,1B,80,40,20,10,08,04,02,01; IDLE Rcon is 0x36 while decrypt=1.
- Guard strobes, defaults → Guards_MUX_sel high t..t+5 then low for the rest of the run; Guards_KeyReg_EN high at t and t+5+10k for k = 0..9.
- start pulsed mid-RUN and in DONE → ignored, no timing change; start in the cycle after done → accepted.
- rst at t+37 → next cycle is IDLE, busy=0, Guards_MUX_sel=1, no done pulse; a new start then runs the full sequence.
- SBOX_LATENCY=4, NUM_ROUNDS=2, decrypt → Rcon 02,01; done at t+9; FinalRound high t+5..t+8.
